cpu_param: RTL and testbench

CPU_PARAM -- requirements
Module: cpu_param

---
 rtl/cpu_param_if.sv | 32 +++
 rtl/cpu_param.sv | 153 +++++++++++++++
 tb/tb_cpu_param.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_param_if.sv
// cpu_param_if: memory-side bus of the cpu_param accumulator core.
//   instruction   program word at addr_to_pm (opcode in top 5 bits)
//   addr_to_pm    program counter
//   data_from_dm  data-memory read word
//   dm_ready      data memory accepts/completes the current access this cycle
//   data_to_dm    store data (accumulator)
//   addr_to_dm    data address (instruction operand)
//   RdRam/WrRam   data-memory read/write strobes
// master = core side, slave = memory side.
interface cpu_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11
);
    logic [ADDR_W+4:0] instruction;
    logic [ADDR_W-1:0] addr_to_pm;
    logic [DATA_W-1:0] data_from_dm;
    logic              dm_ready;
    logic [DATA_W-1:0] data_to_dm;
    logic [ADDR_W-1:0] addr_to_dm;
    logic              RdRam;
    logic              WrRam;

    modport master (
        input  instruction, data_from_dm, dm_ready,
        output addr_to_pm, data_to_dm, addr_to_dm, RdRam, WrRam
    );

    modport slave (
        output instruction, data_from_dm, dm_ready,
        input  addr_to_pm, data_to_dm, addr_to_dm, RdRam, WrRam
    );
endinterface

// File: rtl/cpu_param.sv
// cpu_param: parameterised single-accumulator core with a RUN / WAIT_DM / HALT
// sequencer and a saturating cycle counter.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   bus          cpu_param_if.master (program/data memory bus)
//   halted       core is in HALT
//   cycle_count  non-HALT cycles since reset, saturating
// Optional feature: define CPU_PARAM_BRANCH_EN to enable JMP/BEQ/BNE
// (opcodes 8..10); otherwise those opcodes are NOPs.
module cpu_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    cpu_param_if.master      bus,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STO  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SUBI = OP_W'(7);
`ifdef CPU_PARAM_BRANCH_EN
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(10);
`endif

    typedef enum logic [1:0] {RUN, WAIT_DM, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] opnd_q, opnd_d;

    logic [OP_W-1:0]   cur_op;
    logic [ADDR_W-1:0] cur_opnd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] mem_res;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_rd, is_wr;

    // Decode: live instruction in RUN/HALT, latched instruction while waiting.
    always_comb begin
        cur_op   = bus.instruction[ADDR_W+4:ADDR_W];
        cur_opnd = bus.instruction[ADDR_W-1:0];
        if (state_q == WAIT_DM) begin
            cur_op   = op_q;
            cur_opnd = opnd_q;
        end
        imm    = DATA_W'($signed(cur_opnd));
        pc_inc = pc_q + ADDR_W'(1);
        is_rd  = (cur_op == OP_LD) || (cur_op == OP_ADD) || (cur_op == OP_SUB);
        is_wr  = (cur_op == OP_STO);
        case (cur_op)
            OP_LD:   mem_res = bus.data_from_dm;
            OP_ADD:  mem_res = acc_q + bus.data_from_dm;
            OP_SUB:  mem_res = acc_q - bus.data_from_dm;
            default: mem_res = acc_q;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        if (state_q != HALT && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            RUN: begin
                if (is_rd || is_wr) begin
                    if (bus.dm_ready) begin
                        acc_d = mem_res;
                        pc_d  = pc_inc;
                    end else begin
                        state_d = WAIT_DM;
                        op_d    = cur_op;
                        opnd_d  = cur_opnd;
                    end
                end else begin
                    pc_d = pc_inc;
                    case (cur_op)
                        OP_HLT: begin
                            state_d = HALT;
                            pc_d    = pc_q;
                        end
                        OP_LDI:  acc_d = imm;
                        OP_ADDI: acc_d = acc_q + imm;
                        OP_SUBI: acc_d = acc_q - imm;
`ifdef CPU_PARAM_BRANCH_EN
                        OP_JMP:  pc_d = cur_opnd;
                        OP_BEQ:  if (acc_q == '0) pc_d = cur_opnd;
                        OP_BNE:  if (acc_q != '0) pc_d = cur_opnd;
`endif
                        default: ;
                    endcase
                end
            end
            WAIT_DM: begin
                if (bus.dm_ready) begin
                    state_d = RUN;
                    acc_d   = mem_res;
                    pc_d    = pc_inc;
                end
            end
            default: ;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
        end
    end

    // Strobes are combinational and forced low during reset and HALT.
    assign bus.RdRam      = !reset && (state_q != HALT) && is_rd;
    assign bus.WrRam      = !reset && (state_q != HALT) && is_wr;
    assign bus.addr_to_dm = cur_opnd;
    assign bus.data_to_dm = acc_q;
    assign bus.addr_to_pm = pc_q;
    assign halted         = !reset && (state_q == HALT);
    assign cycle_count    = cnt_q;
endmodule

// File: tb/tb_cpu_param.sv
module tb_cpu_param;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = 16;
    localparam longint PC_MOD  = 2048;
    localparam longint ACC_MOD = 65536;
    localparam longint CNT_MAX = 65535;

    logic             clk = 1'b0;
    logic             reset;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    cpu_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.master),
        .halted     (halted),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int od);
        logic [4:0]  o;
        logic [10:0] d;
        o = 5'(op);
        d = 11'(od);
        return {o, d};
    endfunction

    // Instruction-level reference model: architectural PC/ACC/counter plus
    // a pending memory instruction waiting for dm_ready.
    longint m_pc = 0, m_acc = 0, m_cnt = 0;
    bit     m_halt = 0, m_wait = 0;
    int     m_wop = 0, m_wod = 0;

    function automatic longint sext(input int od);
        return (od >= 1024) ? (od + ACC_MOD - PC_MOD) : od;
    endfunction

    function automatic bit is_mem(input int op);
        return op == 1 || op == 2 || op == 4 || op == 6;
    endfunction

    always @(posedge clk) begin : model
        int op, od;
        op = m_wait ? m_wop : int'(bus.instruction[15:11]);
        od = m_wait ? m_wod : int'(bus.instruction[10:0]);
        if (reset) begin
            m_pc <= 0; m_acc <= 0; m_cnt <= 0; m_halt <= 0; m_wait <= 0;
        end else if (!m_halt) begin
            if (m_cnt != CNT_MAX) m_cnt <= m_cnt + 1;
            if (is_mem(op)) begin
                if (bus.dm_ready) begin
                    m_wait <= 0;
                    m_pc   <= (m_pc + 1) % PC_MOD;
                    if (op == 2) m_acc <= longint'(bus.data_from_dm);
                    if (op == 4) m_acc <= (m_acc + longint'(bus.data_from_dm)) % ACC_MOD;
                    if (op == 6) m_acc <= (m_acc + ACC_MOD - longint'(bus.data_from_dm)) % ACC_MOD;
                end else begin
                    m_wait <= 1; m_wop <= op; m_wod <= od;
                end
            end else if (op == 0) begin
                m_halt <= 1;
            end else begin
                m_pc <= (m_pc + 1) % PC_MOD;
                if (op == 3) m_acc <= sext(od);
                if (op == 5) m_acc <= (m_acc + sext(od)) % ACC_MOD;
                if (op == 7) m_acc <= (m_acc + ACC_MOD - sext(od)) % ACC_MOD;
`ifdef CPU_PARAM_BRANCH_EN
                if (op == 8) m_pc <= od;
                if (op == 9 && m_acc == 0) m_pc <= od;
                if (op == 10 && m_acc != 0) m_pc <= od;
`endif
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin : compare
        int  op, od;
        bit  erd, ewr;
        if (cmp_en) begin
            op  = m_wait ? m_wop : int'(bus.instruction[15:11]);
            od  = m_wait ? m_wod : int'(bus.instruction[10:0]);
            erd = !reset && !m_halt && (op == 2 || op == 4 || op == 6);
            ewr = !reset && !m_halt && (op == 1);
            chk("pc", bus.addr_to_pm, m_pc);
            chk("acc", bus.data_to_dm, m_acc);
            chk("RdRam", bus.RdRam, erd);
            chk("WrRam", bus.WrRam, ewr);
            chk("halted", halted, !reset && m_halt);
            chk("cycle_count", cycle_count, m_cnt);
            if (erd || ewr) chk("addr_to_dm", bus.addr_to_dm, od);
        end
    end

    task automatic put(input logic [15:0] i, input logic [15:0] d, input logic rdy);
        bus.instruction  = i;
        bus.data_from_dm = d;
        bus.dm_ready     = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        put(ins(31, 0), 16'h0, 1'b1);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        put(ins(2, 5), 16'h0, 1'b1);
        tick();
        cmp_en = 1'b1;
        // Reset state and strobe forcing with a read instruction present.
        put(ins(2, 5), 16'h0, 1'b1);
        chk("rst RdRam", bus.RdRam, 0);
        chk("rst pc", bus.addr_to_pm, 0);
        chk("rst cnt", cycle_count, 0);
        tick();

        // LD / ADD / STO sequence.
        reset = 1'b0;
        put(ins(2, 2), 16'd2, 1'b1); tick();
        put(ins(4, 3), 16'd8, 1'b1); tick();
        put(ins(1, 4), 16'd0, 1'b1);
        chk("sto WrRam", bus.WrRam, 1);
        chk("sto data", bus.data_to_dm, 10);
        tick();
        chk("sto pc", bus.addr_to_pm, 3);

        // Immediates and sign extension.
        put(ins(3, 10), 16'd0, 1'b1); tick();
        put(ins(7, 6), 16'd0, 1'b1); tick();
        put(ins(1, 2), 16'd0, 1'b1);
        chk("subi data", bus.data_to_dm, 4);
        chk("sto addr", bus.addr_to_dm, 2);
        tick();
        put(ins(3, 'h7FF), 16'd0, 1'b1); tick();
        chk("ldi sext", bus.data_to_dm, 16'hFFFF);

        // Memory wait: 3 not-ready cycles then ready; instruction input ignored.
        do_reset();
        put(ins(3, 5), 16'd0, 1'b1); tick();
        put(ins(2, 9), 16'd7, 1'b0);
        chk("wait rd0", bus.RdRam, 1);
        tick();
        for (int k = 1; k < 4; k++) begin
            put(ins(1, 5), 16'd7, (k == 3));
            chk("wait rd", bus.RdRam, 1);
            chk("wait wr", bus.WrRam, 0);
            chk("wait pc", bus.addr_to_pm, 1);
            chk("wait acc", bus.data_to_dm, 5);
            chk("wait addr", bus.addr_to_dm, 9);
            tick();
        end
        chk("ld pc", bus.addr_to_pm, 2);
        chk("ld acc", bus.data_to_dm, 7);
        put(ins(4, 3), 16'd3, 1'b0); tick();
        put(ins(31, 0), 16'd3, 1'b1); tick();
        chk("add wait acc", bus.data_to_dm, 10);
        put(ins(6, 1), 16'd4, 1'b1); tick();
        chk("sub acc", bus.data_to_dm, 6);
        put(ins(12, 0), 16'd0, 1'b1); tick();

        // Reset abandons a pending access.
        put(ins(2, 1), 16'h0, 1'b0); tick();
        reset = 1'b1;
        put(ins(31, 0), 16'h55, 1'b1);
        chk("rst wait RdRam", bus.RdRam, 0);
        tick();
        reset = 1'b0;
        put(ins(31, 0), 16'h55, 1'b1);
        chk("post rst RdRam", bus.RdRam, 0);
        chk("post rst acc", bus.data_to_dm, 0);
        tick();

        // HLT as the fifth instruction, then 10 halted cycles, then reset.
        do_reset();
        put(ins(3, 1), 16'd0, 1'b1); tick();
        put(ins(5, 2), 16'd0, 1'b1); tick();
        put(ins(31, 0), 16'd0, 1'b1); tick();
        put(ins(5, 3), 16'd0, 1'b1); tick();
        put(ins(0, 0), 16'd0, 1'b1); tick();
        put(ins(2, 7), 16'd0, 1'b1);
        repeat (10) tick();
        chk("halt flag", halted, 1);
        chk("halt pc", bus.addr_to_pm, 4);
        chk("halt cnt", cycle_count, 5);
        chk("halt acc", bus.data_to_dm, 6);
        chk("halt RdRam", bus.RdRam, 0);
        do_reset();
        chk("unhalt flag", halted, 0);
        chk("unhalt pc", bus.addr_to_pm, 0);
        chk("unhalt cnt", cycle_count, 0);

        // PC wrap and accumulator wrap.
        put(ins(31, 0), 16'd0, 1'b1);
        repeat (2046) tick();
        put(ins(3, 'h7FF), 16'd0, 1'b1); tick();
        chk("pc top", bus.addr_to_pm, 'h7FF);
        put(ins(5, 1), 16'd0, 1'b1); tick();
        chk("pc wrap", bus.addr_to_pm, 0);
        chk("acc wrap", bus.data_to_dm, 0);

        // Branch opcodes (or NOPs without the feature).
        do_reset();
        put(ins(3, 0), 16'd0, 1'b1); tick();
        put(ins(9, 'h20), 16'd0, 1'b1); tick();
`ifdef CPU_PARAM_BRANCH_EN
        chk("beq pc", bus.addr_to_pm, 'h20);
`else
        chk("beq nop pc", bus.addr_to_pm, 2);
`endif
        put(ins(10, 'h40), 16'd0, 1'b1); tick();
`ifdef CPU_PARAM_BRANCH_EN
        chk("bne pc", bus.addr_to_pm, 'h21);
`else
        chk("bne nop pc", bus.addr_to_pm, 3);
`endif
        put(ins(8, 'h10), 16'd0, 1'b1); tick();

        // Counter saturation.
        do_reset();
        put(ins(31, 0), 16'd0, 1'b1);
        repeat (65540) tick();
        chk("cnt sat", cycle_count, 16'hFFFF);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
